// File: rtl/recovery_transmitter.sv
// recovery_transmitter: sends a read response (len, data, CRC-8 PEC) over a byte TX handshake
module recovery_transmitter #(
  parameter int LenWidth  = 16,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LenWidth-1:0]  len_i,
  input  logic [7:0]           addr_i,
  input  logic                 abort_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic [DataWidth-1:0] word_data_i,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [7:0]           tx_data_o,
  output logic                 busy_o,
  output logic                 done_o
);
  typedef enum logic [2:0] {Idle, TxLenL, TxLenH, TxData, TxPec} state_e;
  state_e state_q, state_d;
  logic [LenWidth-1:0]  len_q, cnt_q;
  logic [DataWidth-1:0] buf_q;
  logic                 buf_valid_q;
  logic [1:0]           idx_q;
  logic [7:0]           pec_q;
  logic                 done_q;
  logic [15:0]          len16;
  logic [7:0]           buf_byte;
  logic                 hs, word_acc;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  assign len16        = 16'(len_q);
  assign buf_byte     = buf_q[{idx_q, 3'b000} +: 8];
  assign busy_o       = state_q != Idle;
  assign done_o       = done_q;
  assign word_ready_o = (state_q == TxData) & ~buf_valid_q;
  assign tx_valid_o   = (state_q == TxLenL) | (state_q == TxLenH) | (state_q == TxPec) |
                        ((state_q == TxData) & buf_valid_q);
  assign hs           = tx_valid_o & tx_ready_i;
  assign word_acc     = word_valid_i & word_ready_o;

  // Outgoing byte mux; idle drives zero
  always_comb begin
    tx_data_o = (state_q == TxLenL) ? len16[7:0] :
                (state_q == TxLenH) ? len16[15:8] :
                (state_q == TxData) ? buf_byte :
                (state_q == TxPec)  ? pec_q : 8'h00;
  end

  // Next-state logic; abort overrides any handshake outside Idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:    state_d = start_i ? TxLenL : Idle;
      TxLenL:  state_d = hs ? TxLenH : TxLenL;
      TxLenH:  state_d = hs ? ((len_q != '0) ? TxData : TxPec) : TxLenH;
      TxData:  state_d = (hs && cnt_q == LenWidth'(1)) ? TxPec : TxData;
      TxPec:   state_d = hs ? Idle : TxPec;
      default: state_d = Idle;
    endcase
    if (abort_i && state_q != Idle) state_d = Idle;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  // Length/counter, word buffer, PEC accumulation and done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      idx_q       <= 2'd0;
      pec_q       <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == Idle) begin
        if (start_i) begin
          len_q       <= len_i;
          cnt_q       <= len_i;
          pec_q       <= crc8(8'h00, addr_i);
          idx_q       <= 2'd0;
          buf_valid_q <= 1'b0;
        end
      end else if (abort_i) begin
        buf_valid_q <= 1'b0;
      end else begin
        if (hs && state_q != TxPec) pec_q <= crc8(pec_q, tx_data_o);
        if (hs && state_q == TxPec) done_q <= 1'b1;
        if (word_acc) begin
          buf_q       <= word_data_i;
          buf_valid_q <= 1'b1;
        end
        if (hs && state_q == TxData) begin
          cnt_q <= cnt_q - LenWidth'(1);
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3 || cnt_q == LenWidth'(1)) buf_valid_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_recovery_transmitter.sv
// tb_recovery_transmitter: table-driven check of response framing, PEC, stalls, gaps, abort and reset
module tb_recovery_transmitter;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
  logic        word_valid = 1'b0, word_ready, tx_valid, busy, done;
  logic [15:0] len = '0;
  logic [7:0]  addr = '0, tx_data;
  logic [31:0] word_data = '0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  recovery_transmitter dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .addr_i(addr), .abort_i(abort),
    .word_valid_i(word_valid), .word_ready_o(word_ready), .word_data_i(word_data),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data), .busy_o(busy), .done_o(done)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] len;
    logic [95:0] w;
    logic [95:0] d;
    int          stall;
    int          gap;
    bit          junk;
    bit          gen;
    int          pec_k;
  } vec_t;

  logic [7:0]  cap [0:2047];
  logic [31:0] wmem[0:127];
  int          ncap = 0, wacc = 0, ndone = 0, done_cyc = 0, hs_cyc = 0, stall_err = 0, wr_cnt = 0, cyc = 0;
  int          wbase = 0, woffer = 0;
  logic        word_en = 1'b1;
  logic        pv = 1'b0, pr = 1'b0, pa = 1'b0;
  logic [7:0]  pd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes, word accepts, done pulses and stall stability at the falling edge
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      cap[ncap % 2048] = tx_data;
      ncap++;
      hs_cyc = cyc;
    end
    if (word_valid && word_ready) wacc++;
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (word_ready) wr_cnt++;
    if (pv && !pr && !pa && rst_n && !(tx_valid && tx_data == pd)) stall_err++;
    pv = tx_valid;
    pr = tx_ready;
    pa = abort;
    pd = tx_data;
  end

  // Word source: offers wmem entries in order, indexed by accepted count
  initial forever begin
    @(posedge clk);
    #2;
    word_valid = word_en && (wacc - wbase < woffer);
    word_data  = wmem[(wacc - wbase) & 127];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] crc_bits(input logic [7:0] r_in, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
    r = r_in;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [15:0] l, input logic [95:0] w,
                              input logic [95:0] d, input int st, input int gp, input bit jk,
                              input bit gn, input int pk);
    vec_t v;
    v.addr = a; v.len = l; v.w = w; v.d = d; v.stall = st; v.gap = gp; v.junk = jk; v.gen = gn; v.pec_k = pk;
    return v;
  endfunction

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] exp[$];
    logic [7:0] crc;
    int         cb, db, wa0, sc, gc, t0, nwe;
    exp.delete();
    exp.push_back(v.len[7:0]);
    exp.push_back(v.len[15:8]);
    for (int k = 0; k < int'(v.len); k++) exp.push_back(v.gen ? 8'(k) : v.d[8*k +: 8]);
    crc = crc_bits(8'h00, v.addr);
    foreach (exp[k]) crc = crc_bits(crc, exp[k]);
    nwe = (int'(v.len) + 3) / 4;
    for (int i = 0; i < nwe + 1; i++)
      wmem[i] = v.gen ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : (i < 3 ? v.w[32*i +: 32] : 32'hDEADBEEF);
    cyc1();
    wbase = wacc; woffer = nwe + 1; word_en = (v.gap == 0);
    cb = ncap; db = ndone; wa0 = wr_cnt; sc = 0; gc = 0;
    addr = v.addr; len = v.len; start = 1'b1;
    cyc1();
    start = 1'b0;
    chk("latency_valid", 32'(tx_valid), 32'd1);
    chk("latency_len_lo", 32'(tx_data), 32'(v.len[7:0]));
    t0 = cyc;
    while (ndone == db && cyc - t0 < 3000) begin
      if (tx_valid && sc < v.stall) begin tx_ready = 1'b0; sc++; end
      else begin tx_ready = 1'b1; sc = 0; end
      if (v.gap > 0 && gc < v.gap && ncap - cb >= 2) begin
        chk("gap_tx_valid", 32'(tx_valid), 32'd0);
        chk("gap_word_ready", 32'(word_ready), 32'd1);
        gc++;
        if (gc == v.gap) word_en = 1'b1;
      end
      if (v.junk) begin
        start = busy;
        addr  = 8'h77;
        len   = 16'h00FF;
      end
      cyc1();
    end
    start = 1'b0; tx_ready = 1'b0;
    chk("done_seen", 32'(ndone - db), 32'd1);
    repeat (2) cyc1();
    chk("done_once", 32'(ndone - db), 32'd1);
    chk("byte_count", 32'(ncap - cb), 32'(exp.size() + 1));
    foreach (exp[k]) chk($sformatf("byte%0d_len%0d", k, v.len), 32'(cap[(cb + k) % 2048]), 32'(exp[k]));
    chk("pec", 32'(cap[(cb + exp.size()) % 2048]), 32'(crc));
    if (v.pec_k >= 0) chk("pec_known", 32'(cap[(cb + exp.size()) % 2048]), 32'(v.pec_k));
    chk("done_latency", 32'(done_cyc - hs_cyc), 32'd1);
    chk("words_accepted", 32'(wacc - wbase), 32'(nwe));
    chk("stall_stable", 32'(stall_err), 32'd0);
    if (v.len == 16'd0) chk("no_word_ready", 32'(wr_cnt - wa0), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    woffer = 0; word_en = 1'b1;
  endtask

  initial begin
    vec_t vt[9];
    int   cb, db, t0;
    vt[0] = mk(8'h00, 16'd1,   96'h000000AB, 96'hAB, 0, 0, 0, 0, 32'h33);
    vt[1] = mk(8'h00, 16'd0,   96'h0, 96'h0, 0, 0, 0, 0, 32'h00);
    vt[2] = mk(8'h5A, 16'd6,   96'h88776655_44332211, 96'h665544332211, 0, 0, 0, 0, -1);
    vt[3] = mk(8'hA5, 16'd4,   96'hDDCCBBAA, 96'hDDCCBBAA, 3, 0, 0, 0, -1);
    vt[4] = mk(8'hA5, 16'd4,   96'hDDCCBBAA, 96'hDDCCBBAA, 0, 0, 0, 0, -1);
    vt[5] = mk(8'h3C, 16'd8,   96'h08070605_04030201, 96'h0807060504030201, 0, 5, 0, 0, -1);
    vt[6] = mk(8'hFF, 16'd3,   96'h00C0FFEE, 96'hC0FFEE, 0, 0, 1, 0, -1);
    vt[7] = mk(8'h12, 16'd9,   96'hBBAA9988_77665544_33221100, 96'h88_77665544_33221100, 1, 0, 0, 0, -1);
    vt[8] = mk(8'h81, 16'd256, 96'h0, 96'h0, 0, 0, 0, 1, -1);

    repeat (3) cyc1();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_word_ready", 32'(word_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    cyc1();

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    wmem[0] = 32'h44332211; wmem[1] = 32'h88776655; wmem[2] = 32'hDEADBEEF;
    cyc1();
    wbase = wacc; woffer = 3; word_en = 1'b1; tx_ready = 1'b1;
    cb = ncap; db = ndone;
    addr = 8'h21; len = 16'd8; start = 1'b1;
    cyc1();
    start = 1'b0;
    t0 = cyc;
    while (!(ncap - cb == 3 && tx_valid) && cyc - t0 < 100) cyc1();
    chk("abort_at_byte", 32'(tx_data), 32'h22);
    tx_ready = 1'b0; abort = 1'b1;
    cyc1();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_word_ready", 32'(word_ready), 32'd0);
    woffer = 0;
    repeat (4) cyc1();
    chk("abort_no_done", 32'(ndone - db), 32'd0);
    chk("abort_no_bytes", 32'(ncap - cb), 32'd3);
    run_vec(vt[7]);

    wmem[0] = 32'h04030201; wmem[1] = 32'hDEADBEEF;
    cyc1();
    wbase = wacc; woffer = 1; tx_ready = 1'b1; cb = ncap;
    addr = 8'h09; len = 16'd4; start = 1'b1;
    cyc1();
    start = 1'b0;
    t0 = cyc;
    while (ncap - cb < 2 && cyc - t0 < 100) cyc1();
    rst_n = 1'b0;
    cyc1();
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    woffer = 0;
    cyc1();
    rst_n = 1'b1;
    cb = ncap; db = ndone;
    repeat (10) cyc1();
    chk("midrst_no_bytes", 32'(ncap - cb), 32'd0);
    chk("midrst_no_done", 32'(ndone - db), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    tx_ready = 1'b0;
    run_vec(vt[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/recovery_transmitter.md
RECOVERY_TRANSMITTER -- requirements
Module: recovery_transmitter

Interface
REQ-001 SHALL have parameter LenWidth, default 16, meaning width of the response byte-count field.
REQ-002 SHALL have parameter DataWidth, default 32, meaning width of a response data word (fixed at 4 bytes).
REQ-003 SHALL have port clk_i  input  1  clock; one clock domain.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  single-cycle request to send one read response.
REQ-006 SHALL have port len_i  input  LenWidth  response payload byte count, sampled on start_i.
REQ-007 SHALL have port addr_i  input  8  target address byte, sampled on start_i, seeds PEC.
REQ-008 SHALL have port abort_i  input  1  bus stop / abort of current response.
REQ-009 SHALL have port word_valid_i  input  1  response data word available.
REQ-010 SHALL have port word_ready_o  output  1  response data word accepted.
REQ-011 SHALL have port word_data_i  input  DataWidth  response data word, byte 0 in bits [7:0].
REQ-012 SHALL have port tx_valid_o  output  1  TTI TX byte valid.
REQ-013 SHALL have port tx_ready_i  input  1  TTI TX byte accepted.
REQ-014 SHALL have port tx_data_o  output  8  TTI TX byte.
REQ-015 SHALL have port busy_o  output  1  high in any state other than Idle.
REQ-016 SHALL have port done_o  output  1  single-cycle pulse after PEC byte accepted.

Function
REQ-017 SHALL implement FSM states Idle, TxLenL, TxLenH, TxData, TxPec; handshake = tx_valid_o & tx_ready_i.
REQ-018 Idle SHALL go to TxLenL on start_i, latching len_i into a byte counter and len register; start_i outside Idle SHALL be ignored.
REQ-019 TxLenL SHALL drive len[7:0], TxLenH SHALL drive len[15:8]; each advances on handshake; tx_valid_o high in both.
REQ-020 TxLenH SHALL go to TxData on handshake if len != 0, else to TxPec.
REQ-021 TxData SHALL hold a 32-bit word buffer with valid flag; word_ready_o = (state == TxData) & !buffer_valid; word accepted on word_valid_i & word_ready_o.
REQ-022 TxData SHALL drive tx_valid_o = buffer_valid, tx_data_o = buffer byte selected by a 2-bit byte index, LSB first.
REQ-023 Each TxData handshake SHALL decrement counter and increment byte index; buffer_valid SHALL clear when byte index wraps 3->0 or counter reaches 0.
REQ-024 On handshake with counter == 1, FSM SHALL go to TxPec; unsent bytes of the last word SHALL be discarded.
REQ-025 TxPec SHALL drive tx_data_o = PEC, tx_valid_o = 1; on handshake go to Idle and assert done_o for one cycle.
REQ-026 PEC SHALL be CRC-8, polynomial x^8+x^2+x+1 (0x07), MSB first, no reflection, no final XOR.
REQ-027 PEC register SHALL load crc8(0x00, addr_i) on start_i, then update on every TxLenL, TxLenH, TxData handshake with the sent byte; PEC byte itself excluded.
REQ-028 abort_i in any non-Idle state SHALL force Idle next cycle, clear buffer_valid, suppress done_o; abort_i has priority over handshake in that cycle.
REQ-029 Latency: start_i in cycle N SHALL give tx_valid_o = 1 with len[7:0] in cycle N+1.
REQ-030 tx_valid_o SHALL remain high with tx_data_o stable until handshake (no retraction except abort).
REQ-031 len = 0xFFFF SHALL send 65535 data bytes without counter wrap.

Reset
REQ-032 On rst_ni low: state Idle, tx_valid_o 0, word_ready_o 0, busy_o 0, done_o 0, tx_data_o 0x00, PEC 0x00, counter 0, buffer_valid 0, byte index 0.
REQ-033 Reset mid-response SHALL discard the response; no byte or done_o after release until a new start_i.

Verification
REQ-034 addr_i=0x00, len_i=1, word 0x000000AB, tx_ready_i=1 -> bytes 0x01,0x00,0xAB,0x33; done_o one cycle after 0x33 handshake; one word consumed.
REQ-035 addr_i=0x00, len_i=0 -> bytes 0x00,0x00,0x00; word_ready_o never high.
REQ-036 len_i=6, words 0x44332211, 0x88776655 -> data 0x11,0x22,0x33,0x44,0x55,0x66; bytes 0x77,0x88 discarded; exactly two words accepted.
REQ-037 len_i=4, tx_ready_i low 3 cycles at each byte -> tx_data_o stable while stalled; byte sequence and PEC identical to unstalled run.
REQ-038 abort_i during second data byte of len_i=8 -> Idle next cycle, busy_o 0, no done_o; following start_i sends full response with correct PEC.
REQ-039 word_valid_i low 5 cycles in TxData -> tx_valid_o 0 during gap, word_ready_o 1, no byte skipped.
